wb_write_queue: RTL and testbench

//  Writer side of the register-file interface. Collects writeback results from
//  the ALU and LSU pipes, orders them in a small FIFO, and drains them one per

---
 rtl/wb_write_queue.sv | 140 ++++++++++++++
 tb/tb_wb_write_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Writeback queue: merges ALU and LSU results into a small FIFO drained one
// entry per cycle onto the register-file write port, with two bypass lookups.
module wb_write_queue #(
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_WIDTH-1:0]  alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_WIDTH-1:0]  lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rw_en,
    output logic [REG_WIDTH-1:0]  rw_addr,
    output logic [DATA_WIDTH-1:0] rw_data,
    input  logic [REG_WIDTH-1:0]  byp1_addr,
    output logic                  byp1_hit,
    output logic [DATA_WIDTH-1:0] byp1_data,
    input  logic [REG_WIDTH-1:0]  byp2_addr,
    output logic                  byp2_hit,
    output logic [DATA_WIDTH-1:0] byp2_data,
    output logic [CNT_W-1:0]      pend_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [REG_WIDTH-1:0]  addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;

    logic             lsu_live;
    logic             alu_live;
    logic             lsu_push;
    logic             alu_push;
    logic             pop;
    logic [PTR_W-1:0] alu_slot;
    logic [CNT_W-1:0] push_cnt;

    // Address-0 requests still handshake but never occupy a slot.
    assign lsu_live = lsu_valid && (lsu_addr != '0);
    assign alu_live = alu_valid && (alu_addr != '0);

    always_comb begin
        lsu_ready = 1'b0;
        alu_ready = 1'b0;
        if (!reset) begin
            lsu_ready = count_reg < CNT_W'(DEPTH);
            alu_ready = (count_reg < CNT_W'(DEPTH - 1)) ||
                        ((count_reg == CNT_W'(DEPTH - 1)) && !lsu_live);
        end
    end

    assign lsu_push = lsu_live && lsu_ready;
    assign alu_push = alu_live && alu_ready;
    assign pop      = !reset && (count_reg != '0);
    assign alu_slot = tail_reg + PTR_W'(lsu_push);
    assign push_cnt = CNT_W'(lsu_push) + CNT_W'(alu_push);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            tail_reg  <= tail_reg + PTR_W'(push_cnt);
            count_reg <= count_reg + push_cnt - CNT_W'(pop);
        end
    end

    // LSU is older when both enqueue, so it takes the tail slot first.
    always_ff @(posedge clk) begin
        if (lsu_push) begin
            addr_mem[tail_reg] <= lsu_addr;
            data_mem[tail_reg] <= lsu_data;
        end
        if (alu_push) begin
            addr_mem[alu_slot] <= alu_addr;
            data_mem[alu_slot] <= alu_data;
        end
    end

    always_comb begin
        rw_en   = pop;
        rw_addr = '0;
        rw_data = '0;
        if (pop) begin
            rw_addr = addr_mem[head_reg];
            rw_data = data_mem[head_reg];
        end
    end

    assign pend_cnt = reset ? '0 : count_reg;

    // Per-slot occupancy: a slot is live when its age from head is below count.
    logic [DEPTH-1:0]      slot_live;
    logic [PTR_W-1:0]      slot_age [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_age[gi]  = PTR_W'(gi) - head_reg;
            assign slot_live[gi] = !reset && (CNT_W'(slot_age[gi]) < count_reg);
        end
    endgenerate

    // Walk from oldest to youngest so the last match is the youngest value.
    function automatic logic [DATA_WIDTH:0] lookup(input logic [REG_WIDTH-1:0] a);
        logic [DATA_WIDTH:0] r;
        logic [PTR_W-1:0]    idx;
        r = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_reg + PTR_W'(k);
            if (slot_live[idx] && (a != '0) && (addr_mem[idx] == a)) begin
                r = {1'b1, data_mem[idx]};
            end
        end
        return r;
    endfunction

    always_comb begin
        byp1_hit  = 1'b0;
        byp1_data = '0;
        byp2_hit  = 1'b0;
        byp2_data = '0;
        {byp1_hit, byp1_data} = lookup(byp1_addr);
        {byp2_hit, byp2_data} = lookup(byp2_addr);
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: hand-computed expectations, one line per
// transaction, with a negedge log of every register-file write.
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        rw_en;
    logic [4:0]  rw_addr;
    logic [31:0] rw_data;
    logic [4:0]  byp1_addr, byp2_addr;
    logic        byp1_hit, byp2_hit;
    logic [31:0] byp1_data, byp2_data;
    logic [2:0]  pend_cnt;

    int checks = 0;
    int errors = 0;
    logic [36:0] wr_log [$];

    wb_write_queue #(.REG_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .rw_en(rw_en), .rw_addr(rw_addr), .rw_data(rw_data),
        .byp1_addr(byp1_addr), .byp1_hit(byp1_hit), .byp1_data(byp1_data),
        .byp2_addr(byp2_addr), .byp2_hit(byp2_hit), .byp2_data(byp2_data),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rw_en) begin
            wr_log.push_back({rw_addr, rw_data});
            $display("write x%0d = 0x%08h", rw_addr, rw_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        alu_addr = '0; alu_data = '0; lsu_addr = '0; lsu_data = '0;
    endtask

    task automatic drive(input logic lv, input logic [4:0] la, input logic av, input logic [4:0] aa);
        lsu_valid = lv; lsu_addr = la; lsu_data = 32'h100 + 32'(la);
        alu_valid = av; alu_addr = aa; alu_data = 32'h100 + 32'(aa);
    endtask

    int exp_c [7] = '{1, 2, 3, 4, 5, 7, 6};

    initial begin
        idle();
        byp1_addr = '0; byp2_addr = '0;
        reset = 1'b1;
        #1;
        // reset cycle outputs
        check("rst_rw_en", 64'(rw_en), 0);
        check("rst_alu_ready", 64'(alu_ready), 0);
        check("rst_lsu_ready", 64'(lsu_ready), 0);
        check("rst_pend", 64'(pend_cnt), 0);
        tick(); tick();
        reset = 1'b0;

        // single ALU write
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
        #1;
        check("a_alu_ready", 64'(alu_ready), 1);
        check("a_rw_en_pre", 64'(rw_en), 0);
        check("a_rw_addr_idle", 64'(rw_addr), 0);
        tick(); idle(); #1;
        check("a_rw_en", 64'(rw_en), 1);
        check("a_rw_addr", 64'(rw_addr), 5);
        check("a_rw_data", 64'(rw_data), 64'h1234);
        check("a_pend1", 64'(pend_cnt), 1);
        tick(); #1;
        check("a_pend0", 64'(pend_cnt), 0);
        check("a_rw_en_off", 64'(rw_en), 0);

        // same-address LSU and ALU in one cycle
        lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'hA;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hB;
        byp1_addr = 5'd3;
        #1;
        check("b_byp_pre", 64'(byp1_hit), 0);
        tick(); idle(); #1;
        check("b_w1_data", 64'(rw_data), 64'hA);
        check("b_pend2", 64'(pend_cnt), 2);
        check("b_byp_hit1", 64'(byp1_hit), 1);
        check("b_byp_data1", 64'(byp1_data), 64'hB);
        tick(); #1;
        check("b_w2_data", 64'(rw_data), 64'hB);
        check("b_w2_addr", 64'(rw_addr), 3);
        check("b_byp_hit2", 64'(byp1_hit), 1);
        check("b_byp_data2", 64'(byp1_data), 64'hB);
        tick(); #1;
        check("b_byp_miss", 64'(byp1_hit), 0);
        check("b_byp_miss_data", 64'(byp1_data), 0);

        // both requesters busy: occupancy and ready throttling
        wr_log.delete();
        drive(1, 5'd1, 1, 5'd2); #1;
        check("c0_pend", 64'(pend_cnt), 0);
        check("c0_alu_ready", 64'(alu_ready), 1);
        tick(); drive(1, 5'd3, 1, 5'd4); #1;
        check("c1_pend", 64'(pend_cnt), 2);
        check("c1_alu_ready", 64'(alu_ready), 1);
        tick(); drive(1, 5'd5, 1, 5'd6); #1;
        check("c2_pend", 64'(pend_cnt), 3);
        check("c2_alu_ready", 64'(alu_ready), 0);
        check("c2_lsu_ready", 64'(lsu_ready), 1);
        tick(); drive(1, 5'd7, 1, 5'd6); #1;
        check("c3_pend", 64'(pend_cnt), 3);
        check("c3_alu_ready", 64'(alu_ready), 0);
        tick(); drive(0, 5'd0, 1, 5'd6); #1;
        check("c4_pend", 64'(pend_cnt), 3);
        check("c4_alu_ready", 64'(alu_ready), 1);
        tick(); idle();
        repeat (5) tick();
        check("c_log_len", 64'(wr_log.size()), 7);
        for (int i = 0; i < 7 && i < wr_log.size(); i++) begin
            check("c_order", 64'(wr_log[i]), 64'({5'(exp_c[i]), 32'h100 + 32'(exp_c[i])}));
        end

        // address 0 is accepted but discarded
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFF;
        byp1_addr = 5'd0;
        #1;
        check("d_alu_ready", 64'(alu_ready), 1);
        tick(); idle(); #1;
        check("d_rw_en", 64'(rw_en), 0);
        check("d_pend", 64'(pend_cnt), 0);
        check("d_byp0", 64'(byp1_hit), 0);

        // fill to 3, discarded LSU frees ALU, then reset drops the queue
        drive(1, 5'd8, 1, 5'd9); tick();
        drive(1, 5'd10, 1, 5'd11); tick();
        drive(1, 5'd0, 1, 5'd12);
        byp2_addr = 5'd11;
        #1;
        check("e_pend3", 64'(pend_cnt), 3);
        check("e_alu_ready", 64'(alu_ready), 1);
        check("e_byp2_hit", 64'(byp2_hit), 1);
        check("e_byp2_data", 64'(byp2_data), 64'h10B);
        tick(); idle();
        reset = 1'b1; byp1_addr = 5'd12;
        wr_log.delete();
        #1;
        check("e_rst_rw_en", 64'(rw_en), 0);
        check("e_rst_pend", 64'(pend_cnt), 0);
        check("e_rst_byp", 64'(byp1_hit), 0);
        tick(); reset = 1'b0; #1;
        check("e_post_pend", 64'(pend_cnt), 0);
        check("e_post_rw_en", 64'(rw_en), 0);
        repeat (3) tick();
        check("e_no_writes", 64'(wr_log.size()), 0);

        // serial ALU writes wrap the pointers
        wr_log.delete();
        for (int i = 1; i <= 10; i++) begin
            alu_valid = 1'b1; alu_addr = 5'(i); alu_data = 32'(i) * 32'h11;
            #1;
            check("f_alu_ready", 64'(alu_ready), 1);
            tick();
        end
        idle();
        repeat (2) tick();
        check("f_log_len", 64'(wr_log.size()), 10);
        for (int i = 0; i < 10 && i < wr_log.size(); i++) begin
            check("f_order", 64'(wr_log[i]), 64'({5'(i + 1), 32'(i + 1) * 32'h11}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
